// File: rtl/udma_tx_ch_pkg.sv
// Shared types and helpers for the uDMA UART TX channel: datasize codes,
// channel state and the per-beat step / data extraction rules.
package udma_tx_ch_pkg;

    localparam logic [1:0] DS_BYTE = 2'd0;
    localparam logic [1:0] DS_HALF = 2'd1;
    localparam logic [1:0] DS_WORD = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

    // Bytes consumed per beat; code 3 behaves as a word.
    function automatic logic [2:0] step_bytes(input logic [1:0] datasize);
        case (datasize)
            DS_BYTE: return 3'd1;
            DS_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extract_beat(input logic [31:0] rdata,
                                                 input logic [1:0]  offset,
                                                 input logic [1:0]  datasize);
        case (datasize)
            DS_BYTE: return {24'h0, 8'(rdata >> {offset, 3'b000})};
            DS_HALF: return {16'h0, 16'(rdata >> {offset[1], 4'b0000})};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/udma_tx_resp_buf.sv
// Two-entry valid/ready response buffer with flush; push and pop may
// coincide, including when full.
module udma_tx_resp_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [31:0] data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] data_o,
    output logic [1:0]  count_o
);

    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        do_pop, do_push;

    assign do_pop  = ready_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage words are reset too, so data_o reads 0 out of reset.
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/udma_uart_tx_channel.sv
// Single-channel uDMA TX engine: turns UART TX beat requests into L2 reads
// for one programmed transfer (plus one queued), and returns aligned data.
module udma_uart_tx_channel
    import udma_tx_ch_pkg::*;
#(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic                      sys_clk_i,
    input  logic                      rstn_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_size_i,
    input  logic [1:0]                cfg_datasize_i,
    input  logic                      cfg_continuous_i,
    input  logic                      cfg_en_i,
    input  logic                      cfg_clr_i,
    output logic                      cfg_en_o,
    output logic                      cfg_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
    output logic                      eot_o,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic [31:0]               data_o,
    output logic                      data_valid_o,
    input  logic                      data_ready_i,
    output logic                      l2_req_o,
    input  logic                      l2_gnt_i,
    output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
    input  logic [31:0]               l2_rdata_i,
    input  logic                      l2_rvalid_i
);

    ch_state_e                 state_q, state_d;
    logic [L2_AWIDTH_NOAL-1:0] curr_addr_q, curr_addr_d, start_q, start_d, pend_addr_q, pend_addr_d;
    logic [TRANS_SIZE-1:0]     bytes_left_q, bytes_left_d, size_q, size_d, pend_size_q, pend_size_d;
    logic [1:0]                ds_q, ds_d, pend_ds_q, pend_ds_d, infl_off_q, infl_off_d, infl_ds_q, infl_ds_d;
    logic                      cont_q, cont_d, pend_cont_q, pend_cont_d;
    logic                      pend_valid_q, pend_valid_d, inflight_q, inflight_d;

    logic [2:0]  step;
    logic [1:0]  buf_count;
    logic        credit, req, gnt, last, en_ok, buf_push;

    assign step   = step_bytes(ds_q);
    // At most two beats outstanding, so the 2-entry buffer can never overflow.
    assign credit = ({1'b0, buf_count} + {2'b00, inflight_q}) < 3'd2;
    assign req    = (state_q == RUN) && data_req_i && (bytes_left_q != '0) && credit;
    assign gnt    = req && l2_gnt_i && !cfg_clr_i;
    assign last   = gnt && (bytes_left_q <= TRANS_SIZE'(step));
    assign en_ok  = cfg_en_i && (cfg_size_i != '0);

    always_comb begin
        state_d      = state_q;
        curr_addr_d  = curr_addr_q;
        bytes_left_d = bytes_left_q;
        start_d      = start_q;
        size_d       = size_q;
        ds_d         = ds_q;
        cont_d       = cont_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_size_d  = pend_size_q;
        pend_ds_d    = pend_ds_q;
        pend_cont_d  = pend_cont_q;
        inflight_d   = 1'b0;
        infl_off_d   = infl_off_q;
        infl_ds_d    = infl_ds_q;
        if (cfg_clr_i) begin
            state_d      = IDLE;
            bytes_left_d = '0;
            pend_valid_d = 1'b0;
        end else begin
            inflight_d = gnt;
            if (gnt) begin
                infl_off_d = curr_addr_q[1:0];
                infl_ds_d  = ds_q;
            end
            if (state_q == IDLE) begin
                if (en_ok) begin
                    state_d      = RUN;
                    curr_addr_d  = cfg_startaddr_i;
                    start_d      = cfg_startaddr_i;
                    bytes_left_d = cfg_size_i;
                    size_d       = cfg_size_i;
                    ds_d         = cfg_datasize_i;
                    cont_d       = cfg_continuous_i;
                end
            end else begin
                if (en_ok && !pend_valid_q) begin
                    pend_valid_d = 1'b1;
                    pend_addr_d  = cfg_startaddr_i;
                    pend_size_d  = cfg_size_i;
                    pend_ds_d    = cfg_datasize_i;
                    pend_cont_d  = cfg_continuous_i;
                end
                if (gnt) begin
                    curr_addr_d  = curr_addr_q + L2_AWIDTH_NOAL'(step);
                    bytes_left_d = last ? '0 : bytes_left_q - TRANS_SIZE'(step);
                end
                if (last) begin
                    if (cont_q) begin
                        curr_addr_d  = start_q;
                        bytes_left_d = size_q;
                    end else if (pend_valid_d) begin
                        // Reads the _d slot so an enqueue in this very cycle is taken at once.
                        curr_addr_d  = pend_addr_d;
                        start_d      = pend_addr_d;
                        bytes_left_d = pend_size_d;
                        size_d       = pend_size_d;
                        ds_d         = pend_ds_d;
                        cont_d       = pend_cont_d;
                        pend_valid_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            curr_addr_q  <= '0;
            bytes_left_q <= '0;
            start_q      <= '0;
            size_q       <= '0;
            ds_q         <= DS_BYTE;
            cont_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_size_q  <= '0;
            pend_ds_q    <= DS_BYTE;
            pend_cont_q  <= 1'b0;
            inflight_q   <= 1'b0;
            infl_off_q   <= 2'd0;
            infl_ds_q    <= DS_BYTE;
        end else begin
            state_q      <= state_d;
            curr_addr_q  <= curr_addr_d;
            bytes_left_q <= bytes_left_d;
            start_q      <= start_d;
            size_q       <= size_d;
            ds_q         <= ds_d;
            cont_q       <= cont_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_size_q  <= pend_size_d;
            pend_ds_q    <= pend_ds_d;
            pend_cont_q  <= pend_cont_d;
            inflight_q   <= inflight_d;
            infl_off_q   <= infl_off_d;
            infl_ds_q    <= infl_ds_d;
        end
    end

    // A response arriving in an abort cycle belongs to the cancelled transfer.
    assign buf_push = l2_rvalid_i && inflight_q && !cfg_clr_i;

    udma_tx_resp_buf u_resp_buf (
        .clk     (sys_clk_i),
        .rst_n   (rstn_i),
        .flush_i (cfg_clr_i),
        .push_i  (buf_push),
        .data_i  (extract_beat(l2_rdata_i, infl_off_q, infl_ds_q)),
        .valid_o (data_valid_o),
        .ready_i (data_ready_i),
        .data_o  (data_o),
        .count_o (buf_count)
    );

    assign cfg_en_o         = (state_q == RUN);
    assign cfg_pending_o    = pend_valid_q;
    assign cfg_curr_addr_o  = curr_addr_q;
    assign cfg_bytes_left_o = bytes_left_q;
    assign eot_o            = last;
    assign data_gnt_o       = gnt;
    assign l2_req_o         = req;
    assign l2_addr_o        = curr_addr_q;

endmodule

// File: tb/tb_udma_uart_tx_channel.sv
// Bench for udma_uart_tx_channel: byte-addressed L2 memory, transaction-level
// reference model checked every cycle, plus directed literal expectations.
module tb_udma_uart_tx_channel;

    logic        sys_clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [11:0] cfg_startaddr_i = '0;
    logic [15:0] cfg_size_i = '0;
    logic [1:0]  cfg_datasize_i = '0;
    logic        cfg_continuous_i = 1'b0;
    logic        cfg_en_i = 1'b0;
    logic        cfg_clr_i = 1'b0;
    logic        cfg_en_o, cfg_pending_o, eot_o, data_gnt_o, data_valid_o, l2_req_o;
    logic [11:0] cfg_curr_addr_o, l2_addr_o;
    logic [15:0] cfg_bytes_left_o;
    logic [31:0] data_o;
    logic        data_req_i = 1'b1;
    logic        data_ready_i = 1'b1;
    logic        l2_gnt_i = 1'b1;
    logic [31:0] l2_rdata_i = '0;
    logic        l2_rvalid_i = 1'b0;

    udma_uart_tx_channel #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
        .sys_clk_i(sys_clk_i), .rstn_i(rstn_i),
        .cfg_startaddr_i(cfg_startaddr_i), .cfg_size_i(cfg_size_i),
        .cfg_datasize_i(cfg_datasize_i), .cfg_continuous_i(cfg_continuous_i),
        .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
        .cfg_en_o(cfg_en_o), .cfg_pending_o(cfg_pending_o),
        .cfg_curr_addr_o(cfg_curr_addr_o), .cfg_bytes_left_o(cfg_bytes_left_o),
        .eot_o(eot_o), .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .l2_req_o(l2_req_o), .l2_gnt_i(l2_gnt_i), .l2_addr_o(l2_addr_o),
        .l2_rdata_i(l2_rdata_i), .l2_rvalid_i(l2_rvalid_i)
    );

    initial forever #5 sys_clk_i = ~sys_clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [7:0] mem [4096];

    function automatic int step_of(input logic [1:0] ds);
        return (ds == 2'd0) ? 1 : (ds == 2'd1) ? 2 : 4;
    endfunction

    // Expected beat: the step-sized naturally aligned group of bytes, little-endian.
    function automatic logic [31:0] beat_of(input logic [11:0] a, input logic [1:0] ds);
        int          n = step_of(ds);
        logic [11:0] base = a & ~12'(n - 1);
        logic [31:0] d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = mem[base + 12'(i)];
        return d;
    endfunction

    function automatic logic [31:0] word_at(input logic [11:0] a);
        logic [11:0] b = a & 12'hFFC;
        return {mem[b + 12'd3], mem[b + 12'd2], mem[b + 12'd1], mem[b]};
    endfunction

    typedef struct {
        logic [31:0] data;
        int          avail;
    } beat_t;

    beat_t       q[$];
    logic [31:0] rx[$];
    bit          m_run, m_cont, m_pend, p_cont;
    logic [11:0] m_addr, m_start, p_addr;
    logic [15:0] m_left, m_size, p_size;
    logic [1:0]  m_ds, p_ds;
    int          cyc = 0;
    int          grants = 0, eots = 0, valid_seen = 0;
    logic        rv_next = 1'b0;
    logic [31:0] rd_next = '0;
    logic        e_req, e_gnt, e_eot, e_valid, en_take;
    int          st;

    // Bench-side L2 slave: answers each accepted read one cycle later.
    initial forever begin
        @(posedge sys_clk_i);
        #1;
        l2_rvalid_i = rv_next;
        l2_rdata_i  = rd_next;
    end

    always @(negedge sys_clk_i) begin
        cyc++;
        if (!rstn_i) begin
            m_run = 0; m_pend = 0; m_cont = 0; m_addr = '0; m_left = '0; m_ds = '0;
            q.delete();
            rv_next = 1'b0;
            check("rst_flags", {26'd0, cfg_en_o, cfg_pending_o, eot_o, data_gnt_o, data_valid_o, l2_req_o}, 32'd0);
            check("rst_counters", {4'd0, cfg_curr_addr_o, cfg_bytes_left_o}, 32'd0);
        end else begin
            st      = step_of(m_ds);
            e_req   = m_run && data_req_i && (m_left != 0) && (q.size() < 2);
            e_gnt   = e_req && l2_gnt_i && !cfg_clr_i;
            e_eot   = e_gnt && (int'(m_left) <= st);
            e_valid = (q.size() > 0) && (q[0].avail <= cyc);
            check("en", cfg_en_o, m_run);
            check("pending", cfg_pending_o, m_pend);
            check("curr_addr", cfg_curr_addr_o, m_addr);
            check("bytes_left", cfg_bytes_left_o, m_left);
            check("l2_addr", l2_addr_o, m_addr);
            check("l2_req", l2_req_o, e_req);
            check("gnt", data_gnt_o, e_gnt);
            check("eot", eot_o, e_eot);
            check("valid", data_valid_o, e_valid);
            if (e_valid) check("data", data_o, q[0].data);

            if (data_gnt_o) grants++;
            if (eot_o) eots++;
            if (data_valid_o) valid_seen++;
            if (data_valid_o && data_ready_i) rx.push_back(data_o);
            rv_next = data_gnt_o;
            rd_next = word_at(l2_addr_o);

            en_take = cfg_en_i && (cfg_size_i != 0);
            if (cfg_clr_i) begin
                m_run = 0; m_left = '0; m_pend = 0;
                q.delete();
            end else begin
                if (e_valid && data_ready_i) void'(q.pop_front());
                if (e_gnt) q.push_back('{beat_of(m_addr, m_ds), cyc + 2});
                if (!m_run) begin
                    if (en_take) begin
                        m_run = 1; m_addr = cfg_startaddr_i; m_start = cfg_startaddr_i;
                        m_left = cfg_size_i; m_size = cfg_size_i; m_ds = cfg_datasize_i;
                        m_cont = cfg_continuous_i;
                    end
                end else begin
                    if (en_take && !m_pend) begin
                        m_pend = 1; p_addr = cfg_startaddr_i; p_size = cfg_size_i;
                        p_ds = cfg_datasize_i; p_cont = cfg_continuous_i;
                    end
                    if (e_gnt) begin
                        m_addr = m_addr + 12'(st);
                        m_left = (int'(m_left) > st) ? m_left - 16'(st) : 16'd0;
                    end
                    if (e_eot) begin
                        if (m_cont) begin
                            m_addr = m_start; m_left = m_size;
                        end else if (m_pend) begin
                            m_addr = p_addr; m_start = p_addr; m_left = p_size; m_size = p_size;
                            m_ds = p_ds; m_cont = p_cont; m_pend = 0;
                        end else begin
                            m_run = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk_i);
            #1;
        end
    endtask

    task automatic pulse_en(input logic [11:0] a, input logic [15:0] sz, input logic [1:0] ds, input logic cont);
        cfg_startaddr_i = a; cfg_size_i = sz; cfg_datasize_i = ds; cfg_continuous_i = cont;
        cfg_en_i = 1'b1;
        tick();
        cfg_en_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((cfg_en_o || data_valid_o) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, n < 300, 1'b1);
    endtask

    int g0, e0, n;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33; mem[12'h013] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            mem[12'h100 + 12'(i)] = 8'hA0 + 8'(i);
            mem[12'h104 + 12'(i)] = 8'hB0 + 8'(i);
        end

        #1;
        check("reset_en", cfg_en_o, 1'b0);
        check("reset_valid", data_valid_o, 1'b0);
        tick(3);
        rstn_i = 1'b1;
        tick(2);

        // Byte transfer out of one L2 word
        rx.delete(); g0 = grants; e0 = eots;
        pulse_en(12'h010, 16'd4, 2'd0, 1'b0);
        wait_done("byte");
        check("byte_count", rx.size(), 4);
        if (rx.size() == 4) begin
            check("byte0", rx[0], 32'h11);
            check("byte1", rx[1], 32'h22);
            check("byte2", rx[2], 32'h33);
            check("byte3", rx[3], 32'h44);
        end
        check("byte_grants", grants - g0, 4);
        check("byte_eot", eots - e0, 1);
        check("byte_addr", cfg_curr_addr_o, 12'h014);
        check("byte_left", cfg_bytes_left_o, 16'd0);

        // Backpressure: only two beats may be outstanding
        rx.delete(); g0 = grants;
        data_ready_i = 1'b0;
        pulse_en(12'h100, 16'd8, 2'd2, 1'b0);
        tick(8);
        check("bp_grants", grants - g0, 2);
        check("bp_req", l2_req_o, 1'b0);
        check("bp_valid", data_valid_o, 1'b1);
        data_ready_i = 1'b1;
        wait_done("bp");
        check("bp_count", rx.size(), 2);
        if (rx.size() == 2) begin
            check("bp_word0", rx[0], 32'hA3A2A1A0);
            check("bp_word1", rx[1], 32'hB3B2B1B0);
        end

        // Second enable queued mid-transfer
        g0 = grants; e0 = eots;
        pulse_en(12'h200, 16'd16, 2'd2, 1'b0);
        pulse_en(12'h300, 16'd4, 2'd2, 1'b0);
        check("queue_pending", cfg_pending_o, 1'b1);
        wait_done("queue");
        check("queue_grants", grants - g0, 5);
        check("queue_eot", eots - e0, 2);
        check("queue_addr", cfg_curr_addr_o, 12'h304);
        check("queue_pending_end", cfg_pending_o, 1'b0);

        // Continuous restart over three passes, then abort
        e0 = eots; n = 0;
        pulse_en(12'h040, 16'd4, 2'd1, 1'b1);
        cfg_continuous_i = 1'b0;
        while (eots - e0 < 3 && n < 200) begin
            tick();
            n++;
        end
        check("cont_eot", eots - e0, 3);
        check("cont_addr", cfg_curr_addr_o, 12'h040);
        check("cont_left", cfg_bytes_left_o, 16'd4);
        cfg_clr_i = 1'b1;
        tick();
        cfg_clr_i = 1'b0;
        tick(3);
        check("cont_stopped", cfg_en_o, 1'b0);

        // Abort with a read in flight and a transfer queued
        g0 = grants; e0 = eots; valid_seen = 0;
        pulse_en(12'h080, 16'd16, 2'd2, 1'b0);
        pulse_en(12'h300, 16'd4, 2'd2, 1'b0);
        check("abort_grant", grants - g0, 1);
        check("abort_pending", cfg_pending_o, 1'b1);
        cfg_clr_i = 1'b1;
        tick();
        cfg_clr_i = 1'b0;
        tick(4);
        check("abort_valid", valid_seen, 0);
        check("abort_en", cfg_en_o, 1'b0);
        check("abort_pend", cfg_pending_o, 1'b0);
        check("abort_eot", eots - e0, 0);
        check("abort_left", cfg_bytes_left_o, 16'd0);

        // Odd size with halfwords: saturating final step
        g0 = grants;
        pulse_en(12'h020, 16'd3, 2'd1, 1'b0);
        check("odd_left_start", cfg_bytes_left_o, 16'd3);
        wait_done("odd");
        check("odd_grants", grants - g0, 2);
        check("odd_addr", cfg_curr_addr_o, 12'h024);

        // Address wrap at the top of L2
        g0 = grants;
        pulse_en(12'hFFE, 16'd4, 2'd1, 1'b0);
        wait_done("wrap");
        check("wrap_grants", grants - g0, 2);
        check("wrap_addr", cfg_curr_addr_o, 12'h002);

        // Zero-size enable is ignored
        g0 = grants; e0 = eots;
        pulse_en(12'h500, 16'd0, 2'd0, 1'b0);
        tick(3);
        check("zero_en", cfg_en_o, 1'b0);
        check("zero_grants", grants - g0, 0);
        check("zero_eot", eots - e0, 0);

        // Asynchronous reset with the response buffer full
        g0 = grants;
        data_ready_i = 1'b0;
        pulse_en(12'h100, 16'd16, 2'd2, 1'b0);
        tick(6);
        check("rst_full_grants", grants - g0, 2);
        check("rst_full_valid", data_valid_o, 1'b1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("rst_async_en", cfg_en_o, 1'b0);
        check("rst_async_valid", data_valid_o, 1'b0);
        check("rst_async_req", l2_req_o, 1'b0);
        check("rst_async_addr", cfg_curr_addr_o, 12'h000);
        check("rst_async_left", cfg_bytes_left_o, 16'd0);
        check("rst_async_data", data_o, 32'd0);
        tick();
        rstn_i = 1'b1;
        data_ready_i = 1'b1;
        tick(2);
        check("rst_release_en", cfg_en_o, 1'b0);
        check("rst_release_valid", data_valid_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
